// File: rtl/txrx_bram_bridge.sv
// txrx_bram_bridge: copies one post-processing message from a sender's TX BRAM
// (port B) into the peer's RX BRAM (port B) and runs both sides of the
// PP/network busy handshake. One instance per link direction.
// Optional build macro: TXRX_BRIDGE_OREG_EN -- the TX BRAM output register is
// enabled, so read data returns two cycles after the address instead of one.
module txrx_bram_bridge #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int LINK_DELAY = 0
) (
  input  logic                  clk,
  input  logic                  reset_high,
  input  logic                  busy_PP2Net_TX,
  input  logic                  msg_stored,
  input  logic [ADDR_WIDTH-1:0] sizeTX_msg,
  output logic                  busy_Net2PP_TX,
  output logic                  tx_bram_enb,
  output logic [ADDR_WIDTH-1:0] tx_bram_addrb,
  input  logic [DATA_WIDTH-1:0] tx_bram_doutb,
  input  logic                  busy_PP2Net_RX,
  output logic                  busy_Net2PP_RX,
  output logic                  msg_accessed,
  output logic [ADDR_WIDTH-1:0] sizeRX_msg,
  output logic                  rx_bram_enb,
  output logic                  rx_bram_web,
  output logic [ADDR_WIDTH-1:0] rx_bram_addrb,
  output logic [DATA_WIDTH-1:0] rx_bram_dinb,
  output logic [15:0]           msg_count
);

`ifdef TXRX_BRIDGE_OREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
  localparam logic [7:0]            DRAIN_INIT = 8'(RD_LAT - 1);
  localparam logic [7:0]            DELAY_INIT = 8'(LINK_DELAY - 1);

  typedef enum logic [2:0] {IDLE, COPY, DRAIN, DELAY, NOTIFY} state_t;

  state_t                state_q, state_d;
  logic                  start;
  logic                  pending_q;
  logic [ADDR_WIDTH-1:0] size_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [7:0]            cnt_q;
  logic                  new_msg;

  // Write pipeline: read valid/address delayed by the BRAM read latency
  logic                  v1_q;
  logic [ADDR_WIDTH-1:0] a1_q;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // The sender's own busy flag does not gate acceptance
  logic unused_busy_tx;
  assign unused_busy_tx = busy_PP2Net_TX;

  assign new_msg = msg_stored && (sizeTX_msg != '0);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!busy_PP2Net_RX && (new_msg || pending_q)) begin
          start   = 1'b1;
          state_d = COPY;
        end
      end
      COPY:   if (rd_addr_q == size_q - ONE) state_d = DRAIN;
      DRAIN:  if (cnt_q == '0) state_d = (LINK_DELAY == 0) ? NOTIFY : DELAY;
      DELAY:  if (cnt_q == '0) state_d = NOTIFY;
      NOTIFY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus message bookkeeping (size, pending, counters)
  always_ff @(posedge clk) begin
    if (reset_high) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      size_q     <= '0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      sizeRX_msg <= '0;
      msg_count  <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && new_msg) size_q <= sizeTX_msg;

      if (start)
        pending_q <= 1'b0;
      else if (state_q == IDLE && new_msg && busy_PP2Net_RX)
        pending_q <= 1'b1;

      if (start)
        rd_addr_q <= '0;
      else if (state_q == COPY && state_d == COPY)
        rd_addr_q <= rd_addr_q + ONE;

      // One counter serves DRAIN and DELAY; it is preloaded on the way in
      if (state_q == COPY)
        cnt_q <= DRAIN_INIT;
      else if (state_q == DRAIN && state_d == DELAY)
        cnt_q <= DELAY_INIT;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - 8'd1;

      // Size and count are updated entering NOTIFY so they are visible with msg_accessed
      if (state_d == NOTIFY) begin
        sizeRX_msg <= size_q;
        msg_count  <= msg_count + 16'd1;
      end
    end
  end

  // Read-to-write delay line; addresses only advance on valid so they hold when idle
  always_ff @(posedge clk) begin
    if (reset_high) begin
      v1_q <= 1'b0;
      a1_q <= '0;
    end else begin
      v1_q <= (state_q == COPY);
      if (state_q == COPY) a1_q <= rd_addr_q;
    end
  end

`ifdef TXRX_BRIDGE_OREG_EN
  logic                  v2_q;
  logic [ADDR_WIDTH-1:0] a2_q;

  // Second delay stage matching the TX BRAM output register
  always_ff @(posedge clk) begin
    if (reset_high) begin
      v2_q <= 1'b0;
      a2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) a2_q <= a1_q;
    end
  end

  assign wr_valid = v2_q;
  assign wr_addr  = a2_q;
`else
  assign wr_valid = v1_q;
  assign wr_addr  = a1_q;
`endif

  assign tx_bram_addrb = rd_addr_q;
  assign rx_bram_addrb = wr_addr;

  // Output decode from state and write pipeline
  always_comb begin
    tx_bram_enb    = (state_q == COPY);
    busy_Net2PP_TX = (state_q == COPY) || (state_q == DRAIN);
    busy_Net2PP_RX = (state_q == COPY) || (state_q == DRAIN) || (state_q == DELAY);
    msg_accessed   = (state_q == NOTIFY);
    rx_bram_enb    = wr_valid;
    rx_bram_web    = wr_valid;
    rx_bram_dinb   = wr_valid ? tx_bram_doutb : '0;
  end

endmodule
